av2_recon_writer: RTL and testbench

AV2_RECON_WRITER -- requirements
Module: av2_recon_writer

---
 rtl/av2_recon_pkg.sv | 25 ++
 rtl/av2_recon_clip_lane.sv | 32 +++
 rtl/av2_recon_writer.sv | 164 ++++++++++++++++
 tb/tb_av2_recon_writer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/av2_recon_pkg.sv
// Shared definitions for the reconstruction writer: FSM encoding, sum width
// and legal block-edge limits.
package av2_recon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int SUM_W    = 18;
   localparam int LOG2_MIN = 2;
   localparam int LOG2_MAX = 6;

   function automatic logic [2:0] sat_log2(input logic [2:0] v, input logic [2:0] vmax);
      if (v < 3'(LOG2_MIN))
         return 3'(LOG2_MIN);
      else if (v > vmax)
         return vmax;
      else
         return v;
   endfunction

endpackage

// File: rtl/av2_recon_clip_lane.sv
// One reconstruction lane: prediction plus signed residual, clamped to the
// active bit depth.
module av2_recon_clip_lane
   import av2_recon_pkg::*;
#(
   parameter int PIXEL_WIDTH = 10
) (
   input  logic                   [PIXEL_WIDTH-1:0] i_pred,
   input  logic signed            [15:0]            i_resid,
   input  logic                   [3:0]             i_bit_depth,
   output logic                   [PIXEL_WIDTH-1:0] o_recon
);

   function automatic logic [PIXEL_WIDTH-1:0] clamp_px(input logic signed [SUM_W-1:0] s,
                                                       input logic [3:0] d);
      logic signed [SUM_W-1:0] mx;
      mx = $signed((SUM_W'(1) << d) - SUM_W'(1));
      if (s[SUM_W-1])
         return '0;
      else if (s > mx)
         return mx[PIXEL_WIDTH-1:0];
      else
         return s[PIXEL_WIDTH-1:0];
   endfunction

   logic signed [SUM_W-1:0] w_sum;

   assign w_sum   = $signed({{(SUM_W-PIXEL_WIDTH){1'b0}}, i_pred})
                  + $signed({{(SUM_W-16){i_resid[15]}}, i_resid});
   assign o_recon = clamp_px(w_sum, i_bit_depth);

endmodule

// File: rtl/av2_recon_writer.sv
// Reconstruction writer: walks a block in raster beats, adds residual to
// prediction per lane and issues cropped, addressed frame writes.
module av2_recon_writer
   import av2_recon_pkg::*;
#(
   parameter int PIXEL_WIDTH  = 10,
   parameter int LANES        = 16,
   parameter int MAX_BLK_LOG2 = 6,
   parameter int ADDR_W       = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [15:0]                  blk_x,
   input  logic [15:0]                  blk_y,
   input  logic [2:0]                   blk_w_log2,
   input  logic [2:0]                   blk_h_log2,
   input  logic [15:0]                  frame_width,
   input  logic [15:0]                  frame_height,
   input  logic [3:0]                   bit_depth,
   input  logic [LANES*PIXEL_WIDTH-1:0] pred_data,
   input  logic [LANES*16-1:0]          resid_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [LANES*PIXEL_WIDTH-1:0] wr_data,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic [LANES-1:0]             wr_mask,
   output logic                         wr_valid,
   input  logic                         wr_ready,
   output logic                         busy,
   output logic                         done
);

   localparam int         CNT_W = 8;
   localparam logic [2:0] LMAX  = 3'((MAX_BLK_LOG2 < LOG2_MAX) ? MAX_BLK_LOG2 : LOG2_MAX);

   function automatic logic [3:0] sat_depth(input logic [3:0] d);
      if (d < 4'd8)
         return 4'd8;
      else if (d > 4'(PIXEL_WIDTH))
         return 4'(PIXEL_WIDTH);
      else
         return d;
   endfunction

   state_t                         r_state, w_state_nxt;
   logic [15:0]                    r_blk_x, r_blk_y, r_fw, r_fh;
   logic [2:0]                     r_w_log2, r_h_log2;
   logic [3:0]                     r_depth;
   logic [CNT_W-1:0]               r_col, r_row;
   logic [CNT_W-1:0]               w_blk_w, w_blk_h;
   logic                           w_last_col, w_last_row, w_accept, w_row_in;
   logic [16:0]                    w_row_abs, w_col_abs;
   logic [ADDR_W-1:0]              w_addr;
   logic [LANES-1:0]               w_mask;
   logic [LANES*PIXEL_WIDTH-1:0]   w_recon;

   logic                           r_wr_vld_p1;
   logic [LANES*PIXEL_WIDTH-1:0]   r_wr_data_p1;
   logic [ADDR_W-1:0]              r_wr_addr_p1;
   logic [LANES-1:0]               r_wr_mask_p1;

   assign w_blk_w    = CNT_W'(1) << r_w_log2;
   assign w_blk_h    = CNT_W'(1) << r_h_log2;
   assign w_last_col = (r_col + CNT_W'(LANES)) >= w_blk_w;
   assign w_last_row = (r_row == (w_blk_h - CNT_W'(1)));
   assign w_accept   = in_valid && in_ready;

   assign w_row_abs = {1'b0, r_blk_y} + 17'(r_row);
   assign w_col_abs = {1'b0, r_blk_x} + 17'(r_col);
   assign w_row_in  = w_row_abs < {1'b0, r_fh};
   assign w_addr    = ADDR_W'(w_row_abs) * ADDR_W'(r_fw) + ADDR_W'(w_col_abs);

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [16:0] w_lane_x;
      assign w_lane_x    = w_col_abs + 17'(gi);
      assign w_mask[gi]  = ((r_col + CNT_W'(gi)) < w_blk_w) && (w_lane_x < {1'b0, r_fw}) && w_row_in;
      av2_recon_clip_lane #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_clip (
         .i_pred      (pred_data[gi*PIXEL_WIDTH +: PIXEL_WIDTH]),
         .i_resid     (resid_data[gi*16 +: 16]),
         .i_bit_depth (r_depth),
         .o_recon     (w_recon[gi*PIXEL_WIDTH +: PIXEL_WIDTH])
      );
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      busy        = (r_state != ST_IDLE);
      done        = 1'b0;
      case (r_state)
         ST_IDLE:  if (start) w_state_nxt = ST_RUN;
         ST_RUN: begin
            in_ready = !r_wr_vld_p1 || wr_ready;
            if (in_valid && in_ready && w_last_col && w_last_row)
               w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: if (r_wr_vld_p1 && wr_ready) w_state_nxt = ST_DONE;
         ST_DONE: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_blk_x  <= '0;
         r_blk_y  <= '0;
         r_fw     <= '0;
         r_fh     <= '0;
         r_w_log2 <= 3'(LOG2_MIN);
         r_h_log2 <= 3'(LOG2_MIN);
         r_depth  <= 4'd8;
         r_col    <= '0;
         r_row    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && start) begin
            r_blk_x  <= blk_x;
            r_blk_y  <= blk_y;
            r_fw     <= frame_width;
            r_fh     <= frame_height;
            r_w_log2 <= sat_log2(blk_w_log2, LMAX);
            r_h_log2 <= sat_log2(blk_h_log2, LMAX);
            r_depth  <= sat_depth(bit_depth);
            r_col    <= '0;
            r_row    <= '0;
         end else if (w_accept) begin
            if (w_last_col) begin
               r_col <= '0;
               r_row <= r_row + CNT_W'(1);
            end else begin
               r_col <= r_col + CNT_W'(LANES);
            end
         end
      end
   end

   // p1: registered write beat, held while the sink stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_vld_p1  <= 1'b0;
         r_wr_data_p1 <= '0;
         r_wr_addr_p1 <= '0;
         r_wr_mask_p1 <= '0;
      end else if (w_accept) begin
         r_wr_vld_p1  <= 1'b1;
         r_wr_data_p1 <= w_recon;
         r_wr_addr_p1 <= w_addr;
         r_wr_mask_p1 <= w_mask;
      end else if (wr_ready) begin
         r_wr_vld_p1  <= 1'b0;
      end
   end

   assign wr_valid = r_wr_vld_p1;
   assign wr_data  = r_wr_data_p1;
   assign wr_addr  = r_wr_addr_p1;
   assign wr_mask  = r_wr_mask_p1;

endmodule

// File: tb/tb_av2_recon_writer.sv
// Scoreboard bench for av2_recon_writer: directed blocks push expected beats,
// a negedge monitor pops and compares every accepted write.
module tb_av2_recon_writer;

   localparam int PW   = 10;
   localparam int LN   = 16;
   localparam int MAXL = 6;
   localparam int AW   = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [15:0]       blk_x = '0, blk_y = '0, frame_width = '0, frame_height = '0;
   logic [2:0]        blk_w_log2 = '0, blk_h_log2 = '0;
   logic [3:0]        bit_depth = 4'd8;
   logic [LN*PW-1:0]  pred_data = '0;
   logic [LN*16-1:0]  resid_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [LN*PW-1:0]  wr_data;
   logic [AW-1:0]     wr_addr;
   logic [LN-1:0]     wr_mask;
   logic              wr_valid;
   logic              wr_ready = 1'b1;
   logic              busy, done;

   av2_recon_writer #(.PIXEL_WIDTH(PW), .LANES(LN), .MAX_BLK_LOG2(MAXL), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .blk_x(blk_x), .blk_y(blk_y), .blk_w_log2(blk_w_log2), .blk_h_log2(blk_h_log2),
      .frame_width(frame_width), .frame_height(frame_height), .bit_depth(bit_depth),
      .pred_data(pred_data), .resid_data(resid_data),
      .in_valid(in_valid), .in_ready(in_ready),
      .wr_data(wr_data), .wr_addr(wr_addr), .wr_mask(wr_mask),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [LN*PW-1:0] data;
      logic [AW-1:0]    addr;
      logic [LN-1:0]    mask;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   beats_seen = 0;
   int   last_wr_cyc = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] req);
      n_checks++;
      if (got === req) n_pass++;
      else $display("FAIL %s: got %0h required %0h", nm, got, req);
   endtask

   function automatic int model_px(input int p, input int r, input int d);
      int s, mx;
      s  = p + r;
      mx = (1 << d) - 1;
      if (s < 0) return 0;
      if (s > mx) return mx;
      return s;
   endfunction

   function automatic int sat_l2(input int v);
      if (v < 2) return 2;
      if (v > MAXL) return MAXL;
      return v;
   endfunction

   logic [LN*PW-1:0] s_data;
   logic [AW-1:0]    s_addr;
   logic [LN-1:0]    s_mask;
   bit               have_snap = 0;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         have_snap = 0;
      end else begin
         if (wr_valid && !wr_ready) begin
            chk("stall_in_ready", in_ready, 0);
            if (have_snap) begin
               chk("stall_data", wr_data, s_data);
               chk("stall_addr", wr_addr, s_addr);
               chk("stall_mask", wr_mask, s_mask);
            end
            s_data = wr_data;
            s_addr = wr_addr;
            s_mask = wr_mask;
            have_snap = 1;
         end else begin
            have_snap = 0;
         end
         if (wr_valid && wr_ready) begin
            chk("sb_pending", q.size() > 0, 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("wr_data", wr_data, e.data);
               chk("wr_addr", wr_addr, e.addr);
               chk("wr_mask", wr_mask, e.mask);
            end
            beats_seen++;
            last_wr_cyc = cyc;
         end
      end
   end

   task automatic run_block(input string nm, input int bx, input int by, input int wl2, input int hl2,
                            input int fw, input int fh, input int dep,
                            input int pb, input int ps, input int rb, input int rs,
                            input int explane, input bit stall, input bit midstart);
      int ew, eh, nb, beats0, t, dcyc;
      bit ok;
      exp_t e;
      logic [LN*PW-1:0] pd;
      logic [LN*16-1:0] rd;
      ew = 1 << sat_l2(wl2);
      eh = 1 << sat_l2(hl2);
      for (int i = 0; i < LN; i++) begin
         pd[i*PW +: PW] = PW'(pb + i*ps);
         rd[i*16 +: 16] = 16'(rb + i*rs);
         e.data[i*PW +: PW] = (explane >= 0) ? PW'(explane) : PW'(model_px(pb + i*ps, rb + i*rs, dep));
      end
      @(posedge clk); #1;
      blk_x = 16'(bx); blk_y = 16'(by); blk_w_log2 = 3'(wl2); blk_h_log2 = 3'(hl2);
      frame_width = 16'(fw); frame_height = 16'(fh); bit_depth = 4'(dep);
      start = 1;
      @(posedge clk); #1;
      start = 0;
      chk({nm, "_busy"}, busy, 1);
      blk_x = 16'hFFFF; blk_y = 16'hFFFF; blk_w_log2 = 3'd3; blk_h_log2 = 3'd5;
      frame_width = 16'd7; frame_height = 16'd3; bit_depth = 4'd9;
      beats0 = beats_seen;
      nb = 0;
      if (stall) begin
         fork
            begin
               repeat (4) @(posedge clk);
               #1 wr_ready = 0;
               repeat (5) @(posedge clk);
               #1 wr_ready = 1;
            end
         join_none
      end
      for (int r = 0; r < eh; r++) begin
         for (int c = 0; c < ew; c += LN) begin
            e.addr = AW'((by + r) * fw + bx + c);
            for (int i = 0; i < LN; i++)
               e.mask[i] = (c + i < ew) && (bx + c + i < fw) && (by + r < fh);
            q.push_back(e);
            pred_data = pd;
            resid_data = rd;
            in_valid = 1;
            if (midstart && nb == 1) start = 1;
            ok = 0;
            t = 0;
            while (!ok && t < 100) begin
               @(negedge clk);
               ok = in_ready;
               @(posedge clk); #1;
               t++;
            end
            start = 0;
            chk({nm, "_accept"}, ok, 1);
            nb++;
         end
      end
      in_valid = 0;
      ok = 0;
      t = 0;
      while (!ok && t < 200) begin
         @(negedge clk);
         ok = done;
         t++;
      end
      dcyc = cyc;
      chk({nm, "_done_seen"}, ok, 1);
      chk({nm, "_done_latency"}, dcyc, last_wr_cyc + 1);
      chk({nm, "_beats"}, beats_seen - beats0, ((ew + LN - 1) / LN) * eh);
      chk({nm, "_sb_empty"}, q.size(), 0);
      @(negedge clk);
      chk({nm, "_done_pulse"}, done, 0);
      chk({nm, "_busy_idle"}, busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wr_valid", wr_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wr_mask", wr_mask, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_wr_addr", wr_addr, 0);
      rst = 0;

      //          name        bx  by wl hl  fw   fh  dep pb ps  rb  rs  exp  stall mid
      run_block("full16",      0,  0, 4, 4,  64,  64, 10, 512, 0, 600, 0, 1023, 0, 0);
      run_block("neg_clamp",  10,  5, 3, 2, 100, 100,  8, 100, 0,-700, 0,    0, 0, 0);
      run_block("pos_clamp",   3,  2, 2, 2,  50,  50,  8, 200, 0, 100, 0,  255, 0, 1);
      run_block("xcrop",     120,  8, 4, 2, 128,  64, 10,  40, 0,   2, 0,   42, 0, 0);
      run_block("ycrop",      16, 70, 4, 2, 128,  64, 10,  40, 0,  -2, 0,   38, 0, 0);
      run_block("stall",      32, 16, 5, 3, 256, 256, 10, 300, 0, -50, 0,  250, 1, 0);
      run_block("sat_log2",    0,  0, 7, 1, 512, 512,  9,   5, 0,   3, 0,    8, 0, 0);
      run_block("ramp",        0,  0, 4, 2,  16,   4, 10,   0,60,-200,40,   -1, 0, 0);

      // Reset while a beat is held in the output register mid-block
      @(posedge clk); #1;
      blk_x = 0; blk_y = 0; blk_w_log2 = 3'd4; blk_h_log2 = 3'd4;
      frame_width = 16'd64; frame_height = 16'd64; bit_depth = 4'd10;
      wr_ready = 0;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      in_valid = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_wr_valid", wr_valid, 1);
      #2 rst = 1;
      #1;
      chk("mid_rst_wr_valid", wr_valid, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_wr_mask", wr_mask, 0);
      chk("mid_rst_wr_data", wr_data, 0);
      chk("mid_rst_wr_addr", wr_addr, 0);
      in_valid = 0;
      @(posedge clk); #1;
      rst = 0;
      wr_ready = 1;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_no_write", wr_valid, 0);
      end
      run_block("after_rst",   8,  4, 3, 3,  64,  64, 10, 700, 0, 100, 0,  800, 0, 0);

      chk("final_sb_empty", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
